// File: rtl/bcd_separator.sv
// bcd_separator: iterative binary-to-BCD converter using shift-add-3
// (double-dabble). One input bit is consumed per clock. A start/busy/done
// handshake frames each conversion, and a sticky flag reports values that
// need more than DIGITS decimal digits.
module bcd_separator #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      numero,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            unidades,
    output logic [3:0]            decenas,
    output logic                  overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic S_IDLE    = 1'b0;
    localparam logic S_CONVERT = 1'b1;

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic             state_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [SW-1:0]    scratch_reg;
    logic [CW-1:0]    cnt_reg;
    logic             ovf_reg;
    logic [SW-1:0]    digits_reg;
    logic             overflow_reg;
    logic             done_reg;

    logic [SW-1:0]    adjusted;
    logic [SW-1:0]    scratch_next;
    logic [WIDTH-1:0] bin_next;
    logic             shift_out;

    // Add-3 correction: each digit is adjusted independently, so the whole
    // layer is DIGITS parallel compare/add units with no carry between them.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
            assign adjusted[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                       ? scratch_reg[4*gi +: 4] + 4'd3
                                       : scratch_reg[4*gi +: 4];
        end
    endgenerate

    // The adjusted accumulator and the binary register shift as one word;
    // the MSB of the binary value enters the units digit, and the top bit of
    // the accumulator falls off into the overflow flag.
    assign shift_out    = adjusted[SW-1];
    assign scratch_next = {adjusted[SW-2:0], bin_reg[WIDTH-1]};
    assign bin_next     = {bin_reg[WIDTH-2:0], 1'b0};

    // Control FSM plus datapath: load on accept, iterate WIDTH times, then
    // publish the result and return to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            bin_reg      <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            digits_reg   <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        bin_reg     <= numero;
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_INIT;
                        ovf_reg     <= 1'b0;
                        state_reg   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bin_reg     <= bin_next;
                    scratch_reg <= scratch_next;
                    ovf_reg     <= ovf_reg | shift_out;
                    cnt_reg     <= cnt_reg - CNT_LAST;
                    if (cnt_reg == CNT_LAST) begin
                        digits_reg   <= scratch_next;
                        overflow_reg <= ovf_reg | shift_out;
                        done_reg     <= 1'b1;
                        state_reg    <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_reg == S_CONVERT);
    assign done     = done_reg;
    assign digits   = digits_reg;
    assign overflow = overflow_reg;
    assign unidades = digits_reg[3:0];

    // The tens digit exists only when at least two digits are produced.
    generate
        if (DIGITS >= 2) begin : g_tens
            assign decenas = digits_reg[7:4];
        end else begin : g_no_tens
            assign decenas = 4'd0;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_separator.sv
// Self-checking bench for bcd_separator: three instances (8/3, 8/2, 16/5)
// checked against an arithmetic decimal-digit model.
module tb_bcd_separator;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: WIDTH=8, DIGITS=3
    logic        start_a;
    logic [7:0]  numero_a;
    logic        busy_a, done_a, ovf_a;
    logic [11:0] digits_a;
    logic [3:0]  uni_a, dec_a;

    // Instance B: WIDTH=8, DIGITS=2
    logic        start_b;
    logic [7:0]  numero_b;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  digits_b;
    logic [3:0]  uni_b, dec_b;

    // Instance C: WIDTH=16, DIGITS=5
    logic        start_c;
    logic [15:0] numero_c;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] digits_c;
    logic [3:0]  uni_c, dec_c;

    bcd_separator #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .numero(numero_a),
        .busy(busy_a), .done(done_a), .digits(digits_a),
        .unidades(uni_a), .decenas(dec_a), .overflow(ovf_a)
    );

    bcd_separator #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .numero(numero_b),
        .busy(busy_b), .done(done_b), .digits(digits_b),
        .unidades(uni_b), .decenas(dec_b), .overflow(ovf_b)
    );

    bcd_separator #(.WIDTH(16), .DIGITS(5)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .numero(numero_c),
        .busy(busy_c), .done(done_c), .digits(digits_c),
        .unidades(uni_c), .decenas(dec_c), .overflow(ovf_c)
    );

    // Decimal reference: peel off base-10 digits; anything left over means
    // the value needs more digits than available.
    function automatic void ref_bcd(input longint v, input int nd,
                                    output logic [19:0] d, output logic o);
        longint r;
        r = v;
        d = '0;
        for (int k = 0; k < nd; k++) begin
            d[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        o = (r != 0);
    endfunction

    // Drivers: called at posedge+1; return edges from accept to done and
    // the number of sampled cycles with busy high. numero is scrambled after
    // the accepting edge so the latched copy is what gets converted.
    task automatic run_a(input logic [7:0] n, output int lat, output int bcyc);
        numero_a = n; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; numero_a = 8'($urandom);
        lat = 0; bcyc = 0;
        while (done_a !== 1'b1 && lat < 40) begin
            if (busy_a === 1'b1) bcyc++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_b(input logic [7:0] n, output int lat);
        numero_b = n; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; numero_b = 8'($urandom);
        lat = 0;
        while (done_b !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_c(input logic [15:0] n, output int lat);
        numero_c = n; start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0; numero_c = 16'($urandom);
        lat = 0;
        while (done_c !== 1'b1 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (digits_a !== 12'h000) begin errors++; $display("FAIL reset_digits got=%h exp=000", digits_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", ovf_a); end
        $display("reset: busy=%b done=%b digits=%h overflow=%b", busy_a, done_a, digits_a, ovf_a);
    endtask

    task automatic test_basic;
        int lat, bcyc;
        logic [11:0] held;
        run_a(8'd25, lat, bcyc);
        $display("basic 25: lat=%0d busy_cycles=%0d digits=%h ovf=%b", lat, bcyc, digits_a, ovf_a);
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (bcyc != 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcyc); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_a); end
        checks++; if (digits_a !== 12'h025) begin errors++; $display("FAIL basic_digits got=%h exp=025", digits_a); end
        checks++; if (uni_a !== 4'd5) begin errors++; $display("FAIL basic_unidades got=%0d exp=5", uni_a); end
        checks++; if (dec_a !== 4'd2) begin errors++; $display("FAIL basic_decenas got=%0d exp=2", dec_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL basic_overflow got=%b exp=0", ovf_a); end
        held = digits_a;
        @(posedge clk); #1;
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done_a); end
        checks++; if (digits_a !== 12'h025) begin errors++; $display("FAIL basic_hold got=%h exp=025", digits_a); end
        if (held !== digits_a) $display("basic: digits moved after done");
    endtask

    task automatic test_sweep;
        int lat, bcyc;
        logic [19:0] ed;
        logic eo;
        for (int n = 0; n < 100; n++) begin
            ref_bcd(longint'(n), 3, ed, eo);
            run_a(8'(n), lat, bcyc);
            $display("sweep %0d: digits=%h ovf=%b lat=%0d", n, digits_a, ovf_a, lat);
            checks++; if (lat != 8) begin errors++; $display("FAIL sweep_latency n=%0d got=%0d exp=8", n, lat); end
            checks++; if (dec_a !== 4'(n / 10)) begin errors++; $display("FAIL sweep_decenas n=%0d got=%0d exp=%0d", n, dec_a, n / 10); end
            checks++; if (uni_a !== 4'(n % 10)) begin errors++; $display("FAIL sweep_unidades n=%0d got=%0d exp=%0d", n, uni_a, n % 10); end
            checks++; if (digits_a !== ed[11:0] || ovf_a !== eo) begin
                errors++; $display("FAIL sweep_digits n=%0d got=%h/%b exp=%h/%b", n, digits_a, ovf_a, ed[11:0], eo);
            end
        end
    endtask

    task automatic test_random_bounds;
        int lat, bcyc;
        logic [19:0] ed;
        logic eo;
        logic [7:0] n;
        for (int i = 0; i < 22; i++) begin
            if (i == 0) n = 8'd255;
            else if (i == 1) n = 8'd0;
            else n = 8'($urandom_range(255, 0));
            ref_bcd(longint'(n), 3, ed, eo);
            run_a(n, lat, bcyc);
            $display("random8 %0d: digits=%h ovf=%b", n, digits_a, ovf_a);
            checks++; if (digits_a !== ed[11:0] || ovf_a !== eo || lat != 8) begin
                errors++; $display("FAIL random8 n=%0d got=%h/%b lat=%0d exp=%h/%b lat=8", n, digits_a, ovf_a, lat, ed[11:0], eo);
            end
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [19:0] ed;
        logic eo;
        logic [7:0] n;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) n = 8'd199;
            else if (i == 1) n = 8'd42;
            else n = 8'($urandom_range(255, 0));
            ref_bcd(longint'(n), 2, ed, eo);
            run_b(n, lat);
            $display("overflow2 %0d: digits=%h ovf=%b", n, digits_b, ovf_b);
            checks++; if (digits_b !== ed[7:0] || ovf_b !== eo || lat != 8) begin
                errors++; $display("FAIL overflow2 n=%0d got=%h/%b lat=%0d exp=%h/%b lat=8", n, digits_b, ovf_b, lat, ed[7:0], eo);
            end
        end
    endtask

    // start held high: the first result appears WIDTH edges after accept,
    // the done cycle is idle and accepts again, so the next result follows
    // WIDTH+1 edges later.
    task automatic test_back_to_back;
        int c, t1, t2;
        numero_a = 8'd7; start_a = 1'b1;
        @(posedge clk); #1;
        numero_a = 8'd13;
        c = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && c < 60) begin
            if (done_a === 1'b1) begin
                if (t1 < 0) begin
                    t1 = c;
                    checks++; if (digits_a !== 12'h007) begin errors++; $display("FAIL b2b_first got=%h exp=007", digits_a); end
                end else begin
                    t2 = c;
                    checks++; if (digits_a !== 12'h013) begin errors++; $display("FAIL b2b_second got=%h exp=013", digits_a); end
                end
            end
            @(posedge clk); #1; c++;
            if (t1 >= 0 && c == t1 + 1) begin
                checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got=%b exp=1", busy_a); end
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        $display("back_to_back: first=%0d second=%0d", t1, t2);
        checks++; if (t1 != 8) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=8", t1); end
        checks++; if (t2 - t1 != 9) begin errors++; $display("FAIL b2b_spacing got=%0d exp=9", t2 - t1); end
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_ignore_start;
        int lat;
        numero_a = 8'd25; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = 0;
        while (done_a !== 1'b1 && lat < 40) begin
            if (lat == 3) begin start_a = 1'b1; numero_a = 8'd99; end
            else start_a = 1'b0;
            @(posedge clk); #1; lat++;
        end
        start_a = 1'b0;
        $display("ignore_start: lat=%0d digits=%h", lat, digits_a);
        checks++; if (lat != 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
        checks++; if (digits_a !== 12'h025) begin errors++; $display("FAIL ignore_digits got=%h exp=025", digits_a); end
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got=%b exp=0", busy_a); end
    endtask

    task automatic test_reset_abort;
        int lat, bcyc, seen;
        numero_a = 8'd200; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        $display("abort: busy=%b done=%b digits=%h", busy_a, done_a, digits_a);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done_a); end
        checks++; if (digits_a !== 12'h000) begin errors++; $display("FAIL abort_digits got=%h exp=000", digits_a); end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        run_a(8'd200, lat, bcyc);
        $display("after_abort 200: digits=%h lat=%0d", digits_a, lat);
        checks++; if (digits_a !== 12'h200 || lat != 8) begin
            errors++; $display("FAIL abort_reconvert got=%h lat=%0d exp=200 lat=8", digits_a, lat);
        end
    endtask

    task automatic test_wide;
        int lat;
        logic [19:0] ed;
        logic eo;
        logic [15:0] n;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) n = 16'd65535;
            else n = 16'($urandom);
            ref_bcd(longint'(n), 5, ed, eo);
            run_c(n, lat);
            $display("wide %0d: digits=%h ovf=%b lat=%0d", n, digits_c, ovf_c, lat);
            checks++; if (digits_c !== ed || ovf_c !== eo || lat != 16) begin
                errors++; $display("FAIL wide n=%0d got=%h/%b lat=%0d exp=%h/%b lat=16", n, digits_c, ovf_c, lat, ed, eo);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; numero_a = '0;
        start_b = 1'b0; numero_b = '0;
        start_c = 1'b0; numero_c = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        @(posedge clk); #1;
        test_basic;
        test_sweep;
        test_random_bounds;
        test_overflow;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
